// File: rtl/cross_bar_arb_if.sv
// Handshake and select bundle between the four cross_bar requesters and the cross_bar_arb arbiter.
// master = requester/downstream side, slave = arbiter side.
interface cross_bar_arb_if;
  logic [3:0] REQ;
  logic [3:0] LAST;
  logic [1:0] DST0;
  logic [1:0] DST1;
  logic [1:0] DST2;
  logic [1:0] DST3;
  logic [3:0] ORDY;
  logic [1:0] SEL0;
  logic [1:0] SEL1;
  logic [1:0] SEL2;
  logic [1:0] SEL3;
  logic [3:0] GNT;
  logic [3:0] ACK;
  logic [3:0] OVLD;
  logic [3:0] TOUT;

  modport master (
    output REQ, LAST, DST0, DST1, DST2, DST3, ORDY,
    input  SEL0, SEL1, SEL2, SEL3, GNT, ACK, OVLD, TOUT
  );

  modport slave (
    input  REQ, LAST, DST0, DST1, DST2, DST3, ORDY,
    output SEL0, SEL1, SEL2, SEL3, GNT, ACK, OVLD, TOUT
  );
endinterface

// File: rtl/cross_bar_arb.sv
// Per-output round-robin arbiter/sequencer driving the 4x4 cross_bar select lines and burst handshakes.
// Optional stall timeout with forced release is enabled by defining XBAR_TIMEOUT_EN.
module cross_bar_arb #(
  parameter int unsigned TO_CYC = 256
) (
  input  logic            CLK,
  input  logic            RST,
  cross_bar_arb_if.slave  bus
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_e;

  if (TO_CYC < 2 || TO_CYC > 65535) begin : g_bad_to_cyc
    $error("cross_bar_arb: TO_CYC must lie in 2..65535");
  end

  state_e     state_q [4];
  logic [1:0] sel_q   [4];
  logic [1:0] ptr_q   [4];
  logic [3:0] gnt_q;

  logic [1:0] dst     [4];
  logic [3:0] ack;
  logic [3:0] ovld;
  logic [3:0] done;
  logic [3:0] to_hit;
  logic [3:0] win_vld;
  logic [1:0] win_idx [4];

  assign dst[0] = bus.DST0;
  assign dst[1] = bus.DST1;
  assign dst[2] = bus.DST2;
  assign dst[3] = bus.DST3;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      ack[i] = bus.REQ[i] & gnt_q[i] & bus.ORDY[dst[i]];
    end
  end

  // Candidates are scanned from PTRj upward; scanning in reverse lets the nearest one win.
  always_comb begin : p_arb
    logic [1:0] cand;
    for (int j = 0; j < 4; j++) begin
      // NOTE: defaults first so every path assigns every output, otherwise a latch is inferred.
      win_vld[j] = 1'b0;
      win_idx[j] = '0;
      ovld[j]    = (state_q[j] == BUSY) & bus.REQ[sel_q[j]];
      done[j]    = (state_q[j] == BUSY) & ack[sel_q[j]] & bus.LAST[sel_q[j]];
      for (int k = 3; k >= 0; k--) begin
        cand = ptr_q[j] + 2'(k);
        if (bus.REQ[cand] && (dst[cand] == 2'(j)) && !gnt_q[cand]) begin
          win_vld[j] = 1'b1;
          win_idx[j] = cand;
        end
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      // NOTE: these arrays are control state, not storage, so every entry is reset.
      for (int j = 0; j < 4; j++) begin
        state_q[j] <= IDLE;
        sel_q[j]   <= '0;
        ptr_q[j]   <= '0;
      end
      gnt_q <= '0;
    end else begin
      // NOTE: sequential state is updated with non-blocking assignments only.
      for (int j = 0; j < 4; j++) begin
        case (state_q[j])
          IDLE: begin
            if (win_vld[j]) begin
              sel_q[j]          <= win_idx[j];
              gnt_q[win_idx[j]] <= 1'b1;
              state_q[j]        <= BUSY;
            end
          end
          BUSY: begin
            if (done[j] || to_hit[j]) begin
              gnt_q[sel_q[j]] <= 1'b0;
              ptr_q[j]        <= sel_q[j] + 2'd1;
              state_q[j]      <= IDLE;
            end
          end
        endcase
      end
    end
  end

`ifdef XBAR_TIMEOUT_EN
  localparam logic [15:0] TO_LIM = 16'(TO_CYC - 1);

  logic [15:0] stall_q [4];
  logic [3:0]  tout_q;

  always_comb begin
    for (int j = 0; j < 4; j++) begin
      to_hit[j] = (state_q[j] == BUSY) & ~ack[sel_q[j]] & (stall_q[j] == TO_LIM);
    end
  end

  // Counter holds the number of stalled BUSY cycles already seen; it never passes TO_LIM.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int j = 0; j < 4; j++) begin
        stall_q[j] <= '0;
      end
      tout_q <= '0;
    end else begin
      for (int j = 0; j < 4; j++) begin
        if ((state_q[j] == BUSY) && !ack[sel_q[j]] && !to_hit[j]) begin
          stall_q[j] <= stall_q[j] + 16'd1;
        end else begin
          stall_q[j] <= '0;
        end
      end
      tout_q <= to_hit;
    end
  end

  assign bus.TOUT = tout_q;
`else
  assign to_hit   = '0;
  assign bus.TOUT = '0;
`endif

  assign bus.SEL0 = sel_q[0];
  assign bus.SEL1 = sel_q[1];
  assign bus.SEL2 = sel_q[2];
  assign bus.SEL3 = sel_q[3];
  assign bus.GNT  = gnt_q;
  assign bus.ACK  = ack;
  assign bus.OVLD = ovld;

endmodule

// File: tb/tb_cross_bar_arb.sv
// Self-checking bench for cross_bar_arb: directed scenarios plus randomized bursts against a per-output
// ownership model. Timeout scenario and model timeout rule are active when XBAR_TIMEOUT_EN is defined.
module tb_cross_bar_arb;

  localparam int TO = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [3:0] last;
  logic [3:0] ordy;
  logic [1:0] dst [4];

  cross_bar_arb_if bus ();

  assign bus.REQ  = req;
  assign bus.LAST = last;
  assign bus.ORDY = ordy;
  assign bus.DST0 = dst[0];
  assign bus.DST1 = dst[1];
  assign bus.DST2 = dst[2];
  assign bus.DST3 = dst[3];

  cross_bar_arb #(.TO_CYC(TO)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Model: which requester owns each output (-1 = free), last owner, rotation start, stalled-cycle run.
  int         own    [4];
  int         msel   [4];
  int         mptr   [4];
  int         mstall [4];
  logic [3:0] mtout;

  logic [3:0] obs_ack, obs_gnt, obs_tout, exp_ack;

  task automatic model_reset();
    for (int j = 0; j < 4; j++) begin
      own[j]    = -1;
      msel[j]   = 0;
      mptr[j]   = 0;
      mstall[j] = 0;
    end
    mtout = '0;
  endtask

  task automatic model_step(input logic [3:0] g, input logic [3:0] a);
    logic [3:0] nt;
    nt = '0;
    for (int j = 0; j < 4; j++) begin
      if (own[j] < 0) begin
        bit found;
        found = 1'b0;
        for (int k = 0; k < 4; k++) begin
          int i;
          i = (mptr[j] + k) % 4;
          if (!found && req[i] && (int'(dst[i]) == j) && !g[i]) begin
            own[j]  = i;
            msel[j] = i;
            found   = 1'b1;
          end
        end
        mstall[j] = 0;
      end else begin
        int o;
        o = own[j];
        if (a[o] && last[o]) begin
          own[j]    = -1;
          mptr[j]   = (o + 1) % 4;
          mstall[j] = 0;
        end else if (a[o]) begin
          mstall[j] = 0;
        end else begin
          mstall[j]++;
`ifdef XBAR_TIMEOUT_EN
          if (mstall[j] == TO) begin
            own[j]    = -1;
            mptr[j]   = (o + 1) % 4;
            mstall[j] = 0;
            nt[j]     = 1'b1;
          end
`endif
        end
      end
    end
    mtout = nt;
  endtask

  // Entered at posedge+1 with inputs set; compares at negedge, advances model, returns at next posedge+1.
  task automatic cycle();
    logic [3:0] g, a, o;
    @(negedge clk);
    g = '0;
    for (int j = 0; j < 4; j++) if (own[j] >= 0) g[own[j]] = 1'b1;
    for (int i = 0; i < 4; i++) a[i] = req[i] & g[i] & ordy[dst[i]];
    for (int j = 0; j < 4; j++) o[j] = (own[j] >= 0) && req[msel[j]];
    check("gnt",  32'(bus.GNT), 32'(g));
    check("sel",  32'({bus.SEL3, bus.SEL2, bus.SEL1, bus.SEL0}),
                  32'({2'(msel[3]), 2'(msel[2]), 2'(msel[1]), 2'(msel[0])}));
    check("ack",  32'(bus.ACK),  32'(a));
    check("ovld", 32'(bus.OVLD), 32'(o));
    check("tout", 32'(bus.TOUT), 32'(mtout));
    obs_ack  = bus.ACK;
    obs_gnt  = bus.GNT;
    obs_tout = bus.TOUT;
    exp_ack  = a;
    model_step(g, a);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int idx_q[$];
    int cyc_q[$];
    int cnt;
    int rem [4];

    // Reset state, with requests active so ACK/OVLD gating is exercised.
    rst = 1'b1; req = 4'hF; last = 4'h0; ordy = 4'hF;
    for (int i = 0; i < 4; i++) dst[i] = 2'(i);
    model_reset();
    @(negedge clk);
    check("rst_gnt",  32'(bus.GNT), 0);
    check("rst_sel",  32'({bus.SEL3, bus.SEL2, bus.SEL1, bus.SEL0}), 0);
    check("rst_ack",  32'(bus.ACK), 0);
    check("rst_ovld", 32'(bus.OVLD), 0);
    check("rst_tout", 32'(bus.TOUT), 0);
    @(posedge clk); #1;
    rst = 1'b0; req = 4'h0;

    // Reset mid-burst, then re-grant one cycle after REQ.
    dst[0] = 2'd2; req = 4'b0001; last = 4'h0;
    cycle();
    cycle();
    #1 rst = 1'b1;
    #1;
    check("amid_sel2", 32'(bus.SEL2), 0);
    check("amid_gnt",  32'(bus.GNT), 0);
    check("amid_ack",  32'(bus.ACK), 0);
    check("amid_ovld", 32'(bus.OVLD), 0);
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    cycle();
    check("rst_regrant", 32'(bus.GNT), 32'h1);
    last = 4'b0001;
    cycle();
    req = 4'h0; last = 4'h0;
    cycle();

    // Round robin on out1 with single-beat bursts.
    for (int i = 0; i < 4; i++) dst[i] = 2'd1;
    req = 4'hF; last = 4'hF; ordy = 4'hF;
    for (int c = 0; c < 10; c++) begin
      cycle();
      for (int i = 0; i < 4; i++) if (obs_ack[i]) begin idx_q.push_back(i); cyc_q.push_back(c); end
    end
    req = 4'h0; last = 4'h0;
    cycle();
    check("rr_count", 32'(idx_q.size()), 5);
    for (int n = 0; n < idx_q.size() && n < 5; n++) begin
      check("rr_order", 32'(idx_q[n]), 32'(n % 4));
      if (n > 0) check("rr_gap", 32'(cyc_q[n] - cyc_q[n-1]), 2);
    end

    // Parallel paths: four 4-beat bursts to distinct outputs.
    dst[0] = 2'd3; dst[1] = 2'd2; dst[2] = 2'd1; dst[3] = 2'd0;
    req = 4'hF; last = 4'h0;
    cycle();
    check("par_gnt", 32'(bus.GNT), 32'hF);
    check("par_sel", 32'({bus.SEL3, bus.SEL2, bus.SEL1, bus.SEL0}), 32'h1B);
    cnt = 0;
    for (int b = 0; b < 4; b++) begin
      last = (b == 3) ? 4'hF : 4'h0;
      cycle();
      cnt += $countones(obs_ack);
    end
    req = 4'h0; last = 4'h0;
    cycle();
    check("par_acks", 32'(cnt), 16);

    // Backpressure and pause on out0, with a competing requester held off.
    dst[2] = 2'd0; dst[3] = 2'd0; req = 4'b0100; last = 4'h0; ordy = 4'hF;
    cycle();
    req[3] = 1'b1; last[3] = 1'b1;
    cnt = 0;
    cycle();
    cnt += int'(obs_ack[2]);
    ordy[0] = 1'b0;
    for (int c = 0; c < 5; c++) begin
      cycle();
      cnt += int'(obs_ack[2]);
      check("bp_stall_gnt", 32'(obs_gnt), 32'b0100);
    end
    ordy = 4'hF; req[2] = 1'b0;
    for (int c = 0; c < 2; c++) begin
      cycle();
      cnt += int'(obs_ack[2]);
      check("bp_pause_gnt", 32'(obs_gnt), 32'b0100);
    end
    req[2] = 1'b1;
    cycle();
    cnt += int'(obs_ack[2]);
    last[2] = 1'b1;
    cycle();
    cnt += int'(obs_ack[2]);
    req[2] = 1'b0; last[2] = 1'b0;
    cycle();
    cycle();
    req = 4'h0; last = 4'h0;
    cycle();
    check("bp_acks", 32'(cnt), 3);

    // Contention: req1 holds out3 for 6 beats while req0 waits.
    dst[0] = 2'd3; dst[1] = 2'd3; req = 4'b0010; last = 4'h0;
    cycle();
    req[0] = 1'b1;
    for (int b = 0; b < 6; b++) begin
      last[1] = (b == 5);
      cycle();
      check("cont_hold", 32'(obs_gnt[0]), 0);
    end
    req[1] = 1'b0; last[1] = 1'b0;
    check("cont_gap", 32'(bus.GNT[0]), 0);
    cycle();
    check("cont_gnt", 32'(bus.GNT[0]), 1);
    last[0] = 1'b1;
    cycle();
    req = 4'h0; last = 4'h0;
    cycle();

`ifdef XBAR_TIMEOUT_EN
    // Timeout: req3 stalls on out1, req0 waits behind it.
    begin
      int tout_at;
      tout_at = -1;
      dst[3] = 2'd1; dst[0] = 2'd1; req = 4'b1000; last = 4'h0; ordy = 4'hD;
      cycle();
      req[0] = 1'b1;
      for (int k = 1; k <= 12; k++) begin
        cycle();
        if (obs_tout[1] && tout_at < 0) tout_at = k;
        if (k == 9) begin
          check("to_gnt3", 32'(obs_gnt[3]), 0);
          req[3] = 1'b0;
        end
        if (k == 10) check("to_regrant", 32'(obs_gnt[0]), 1);
      end
      check("to_cycle", 32'(tout_at), 9);
      ordy = 4'hF; last[0] = 1'b1;
      cycle();
      req = 4'h0; last = 4'h0;
      cycle();
    end
`endif

    // Randomized bursts.
    for (int i = 0; i < 4; i++) rem[i] = 0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 4; i++) begin
        if (rem[i] == 0 && $urandom_range(2) == 0) begin
          rem[i] = int'($urandom_range(5, 1));
          dst[i] = 2'($urandom_range(3));
        end
        req[i]  = (rem[i] != 0) && ($urandom_range(7) != 0);
        last[i] = (rem[i] == 1);
      end
      ordy = 4'($urandom) | 4'($urandom);
      cycle();
      for (int i = 0; i < 4; i++) if (exp_ack[i] && rem[i] > 0) rem[i]--;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cross_bar_arb.md
Name: cross_bar_arb

Overview:
- Round-robin arbiter and sequencer for the 4x4 cross_bar datapath.
- Four requesters (one per cross_bar input) each name a destination output and transfer a burst of beats.
- Per output: picks one owner, drives cross_bar SELj, holds ownership until the burst's LAST beat, then releases.
- Sits beside cross_bar. INi data goes straight to cross_bar, and this block supplies the SEL0..SEL3 select lines plus the handshakes.

Parameters:
- TO_CYC, 256, stall-timeout cycle count, used only with XBAR_TIMEOUT_EN; legal range 2..65535.

Ports:
- CLK  input  1  clock, rising edge
- RST  input  1  asynchronous reset, active-high
- REQ  input  4  REQ[i]=1: requester i presents a valid beat
- LAST  input  4  LAST[i]=1: current beat of requester i ends its burst
- DST0..DST3  input  2 each  destination output index of requester i; must stay stable from first REQ to LAST transfer
- ORDY  input  4  ORDY[j]=1: downstream of output j accepts a beat this cycle
- SEL0..SEL3  output  2 each  registered; cross_bar select for output j (owner index)
- GNT  output  4  registered; GNT[i]=1: requester i currently owns output DSTi
- ACK  output  4  combinational; ACK[i] = REQ[i] & GNT[i] & ORDY[DSTi], the beat transferred
- OVLD  output  4  combinational; OVLD[j] = BUSYj & REQ[SELj], output j beat valid
- TOUT  output  4  registered one-cycle pulse; TOUT[j]: output j force-released (XBAR_TIMEOUT_EN only; tied 0 otherwise)

Behaviour:
- Reset (async, any time, mid-burst included):
  - SELj=2'b00, GNT=0, TOUT=0, all outputs IDLE, round-robin pointers PTRj=0, stall counters 0.
  - ACK and OVLD are therefore 0.
- Per-output FSM, states IDLE and BUSY:
  - IDLE: candidates = {i : REQ[i] & DSTi==j & GNT[i]==0}.
    - None: stay IDLE.
    - Otherwise: winner = first candidate searching i = PTRj, PTRj+1, ... mod 4.
    - Next edge: SELj<=winner, GNT[winner]<=1, ->BUSY.
  - BUSY: on ACK[SELj] & LAST[SELj], at the next edge: GNT[SELj]<=0, PTRj<=SELj+1 (mod 4), ->IDLE.
  - BUSY with REQ[owner]=0 (burst paused): keep ownership, no release.
- Latency and throughput:
  - Grant is registered one cycle after REQ is seen with the output IDLE; the first ACK is possible that cycle.
  - After a release there is one idle cycle before the next owner's first beat, i.e. a handover gap of 1 cycle.
  - Within a burst: 1 beat/cycle while ORDY=1.
- SELj holds its last owner value while IDLE; it changes only on a grant edge.
- A requester owns at most one output; the GNT[i]==0 candidacy rule enforces this.
- Simultaneous events:
  - Four outputs arbitrate independently in the same cycle; different-destination requesters are granted in parallel.
  - Release and a new request in the same cycle: the new request is arbitrated in the following IDLE cycle, with the pointer already advanced.
  - Single-beat burst (REQ & LAST on the first granted cycle with ORDY=1): one ACK, then release.
- Protocol violation (DSTi changes while GNT[i]=1): no recovery required; ownership stays with the original output until LAST is accepted there.

Optional Feature:
- Macro XBAR_TIMEOUT_EN.
- Defined:
  - Per output, a 16-bit stall counter counts BUSY cycles without ACK[SELj]; it clears on any ACK and on leaving BUSY.
  - When the count reaches TO_CYC-1 with no ACK: next edge GNT[SELj]<=0, PTRj advances, ->IDLE, TOUT[j]=1 for one cycle.
- Not defined: no counters; TOUT is constant 0; ownership is held indefinitely.

Test Plan:
- Reset mid-burst: req0->out2 granted, assert RST -> SEL2=0, GNT=0, ACK=0, OVLD=0 immediately (async); after deassert, req0 is re-granted 1 cycle after REQ.
- Round-robin fairness: REQ=4'b1111, all DST=1, 1-beat bursts, ORDY=1111 -> GNT order 0,1,2,3,0, SEL1 follows; each ACK spaced by 2 cycles.
- Parallel paths: DST0=3, DST1=2, DST2=1, DST3=0, 4-beat bursts -> all four GNT bits set on the same edge; 16 ACKs in 4 cycles; SEL3=0, SEL2=1, SEL1=2, SEL0=3.
- Backpressure/pause: req2->out0 3-beat burst, ORDY[0]=0 for 5 cycles mid-burst, then REQ[2]=0 for 2 cycles -> no ACK, GNT[2] held, no other grant on out0; burst completes with exactly 3 ACKs.
- Contention hold: req1 owns out3 with a 6-beat burst while req0 requests out3 -> req0 waits; granted on the 2nd cycle after req1's LAST ACK; pointer PTR3=2.
- Timeout (XBAR_TIMEOUT_EN, TO_CYC=8): req3 owns out1, ORDY[1]=0 -> TOUT[1] pulses after 8 stalled BUSY cycles, GNT[3]=0; pending req0->out1 is granted next.
